coeff_loader: RTL and testbench
===============================

COEFF_LOADER -- requirements
Module: coeff_loader

Interface
REQ-001 SHALL define parameter NWORDS, default 128, meaning the number of 32-bit words (coefficient pairs) per polynomial.
REQ-002 SHALL define parameter Q, default 3329, meaning the coefficient modulus used by the range check.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port go, input, 1 bit: pulse that requests loading of one polynomial.
REQ-006 SHALL have port mode_sel, input, 1 bit: 0 = NTT, 1 = INTT; sampled on accepted go.
REQ-007 SHALL have port s_valid, input, 1 bit: upstream word valid.
REQ-008 SHALL have port s_data, input, 32 bits: [31:16] is the even coefficient, [15:0] is the odd coefficient.
REQ-009 SHALL have port s_ready, output, 1 bit: loader accepts a word.
REQ-010 SHALL have port done_in, input, 1 bit: transform-complete flag from the downstream NTT core.
REQ-011 SHALL have port start, output, 1 bit: external-address select and load phase for the NTT core.
REQ-012 SHALL have port mode, output, 1 bit: registered copy of mode_sel.
REQ-013 SHALL have port we, output, 1 bit: RAM write enable toward the core.
REQ-014 SHALL have ports address_ina and address_inb, output, 8 bits each: write addresses.
REQ-015 SHALL have ports data_ina and data_inb, output, 16 bits each: write data.
REQ-016 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-017 SHALL have port err, output, 1 bit: sticky range-check error flag.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, SETTLE and RUN.
REQ-019 SHALL move IDLE->LOAD on go=1, latching mode_sel into mode and clearing the word counter and err.
REQ-020 SHALL ignore go in every state except IDLE.
REQ-021 SHALL drive s_ready=1 only in LOAD while the counter is below NWORDS; a word is accepted on s_valid&&s_ready.
REQ-022 SHALL, for accepted word k (0..NWORDS-1), drive in the next cycle: we=1, address_ina=2k, address_inb=2k+1, data_ina=s_data[31:16], data_inb=s_data[15:0] (one-cycle latency).
REQ-023 SHALL drive we=0 in any cycle that has no accepted word in the previous cycle; s_valid stalls insert gaps with no writes.
REQ-024 SHALL move LOAD->SETTLE in the cycle after word NWORDS-1 is accepted (the address_inb=255 write cycle).
REQ-025 SHALL hold start=1 through IDLE-exit, LOAD and SETTLE, so start is still high on the final write.
REQ-026 SHALL move SETTLE->RUN after one cycle, drop start to 0 on RUN entry, and hold mode stable.
REQ-027 SHALL move RUN->IDLE when done_in=1, and SHALL ignore done_in outside RUN.
REQ-028 SHALL keep address_in*/data_in* at their last values while we=0.
REQ-029 SHALL use a word counter wide enough to reach NWORDS without wrap; the counter saturates and never wraps within a load.
REQ-030 SHALL accept a done_in of 1 on the RUN entry cycle, and that case takes priority.

Reset
REQ-031 SHALL, when rst=0 on a clock edge, force state=IDLE, start=0, we=0, s_ready=0, busy=0, mode=0, err=0, addresses=0, data=0 and counter=0, regardless of state.
REQ-032 SHALL treat a reset in mid-LOAD or mid-RUN as an abandoned load; a new go is required to restart.

Configuration
REQ-033 SHALL, when macro COEFF_RANGE_CHECK_EN is defined, set err on any accepted coefficient >= Q and keep it set until reset or the next accepted go.
REQ-034 SHALL, with COEFF_RANGE_CHECK_EN defined, still write the out-of-range coefficient unchanged.
REQ-035 SHALL, without COEFF_RANGE_CHECK_EN, tie err to 0 and build no comparator logic.

Verification
REQ-036 Bench SHALL cover a full load: go with mode_sel=0, then 128 back-to-back words 0x00010002*k -> 128 writes at (2k,2k+1), the last at 254/255, start falls 2 cycles after the last accept, mode=0.
REQ-037 Bench SHALL cover stalls: s_valid toggling every cycle -> we high only in cycles after an accept, 128 writes total, no address skipped or repeated.
REQ-038 Bench SHALL cover done handshake: in RUN, done_in=1 -> IDLE next cycle, busy=0; a go pulse during LOAD/RUN is ignored, so there is no counter clear.
REQ-039 Bench SHALL cover mid-load reset: rst=0 after 50 words -> next cycle start=0, we=0, s_ready=0; a new go restarts at address 0/1.
REQ-040 Bench SHALL cover the range check with COEFF_RANGE_CHECK_EN defined: word 0x0D010005 (3329,5) -> err=1, data_ina=0x0D01 written; without the macro, err stays 0.
REQ-041 Bench SHALL cover INTT: go with mode_sel=1 -> mode=1 from go+1 until the next go, unaffected by mode_sel changes.

Source files
------------

// File: rtl/coeff_loader.sv
// ---------------------------------------------------------------------------
// coeff_loader
//
// Streams one polynomial (NWORDS 32-bit words, two 16-bit coefficients each)
// from a valid/ready source into the coefficient RAM of an NTT core. Then it
// hands control to the core and waits for the core's done flag.
//
// FSM: IDLE -> LOAD -> SETTLE -> RUN -> IDLE
//   IDLE   : waits for go. go latches mode_sel into mode and clears the word
//            counter and err.
//   LOAD   : accepts words. Each accepted word k becomes one RAM write in the
//            next cycle, at addresses (2k, 2k+1).
//   SETTLE : one cycle after the final write, with start still high.
//   RUN    : start is low and the core owns the RAM. Leaves on done_in.
//
// Handshake (upstream): a word transfers on a rising edge where
//   s_valid && s_ready. s_ready depends only on loader state. It is high in
//   LOAD while fewer than NWORDS words have been taken. s_valid may drop at
//   any time; a stall inserts a cycle with we=0. The write addresses and
//   write data hold their last values while we=0.
//
// Ports:
//   clk          clock; all logic is on its rising edge
//   rst          synchronous, active-low reset
//   go           load request; honoured only in IDLE
//   mode_sel     0 = NTT, 1 = INTT; sampled when go is accepted
//   s_valid      upstream word valid
//   s_data       [31:16] even coefficient, [15:0] odd coefficient
//   s_ready      loader accepts a word this cycle
//   done_in      transform complete from the core; honoured only in RUN
//   start        external-address select / load phase (LOAD and SETTLE)
//   mode         registered mode_sel
//   we           RAM write enable
//   address_ina  even-coefficient write address (2k)
//   address_inb  odd-coefficient write address (2k+1)
//   data_ina     even coefficient
//   data_inb     odd coefficient
//   busy         high in any state other than IDLE
//   err          sticky range-check error flag
//   state_dbg    current FSM state (0 IDLE, 1 LOAD, 2 SETTLE, 3 RUN)
//
// Build option: defining COEFF_RANGE_CHECK_EN enables the range check. When
// enabled, err is set if an accepted coefficient is >= Q. The coefficient is
// still written unchanged. When the option is not defined, err is tied to 0.
// ---------------------------------------------------------------------------
module coeff_loader #(
  parameter int NWORDS = 128,
  parameter int Q      = 3329
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        mode_sel,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  input  logic        done_in,
  output logic        start,
  output logic        mode,
  output logic        we,
  output logic [7:0]  address_ina,
  output logic [7:0]  address_inb,
  output logic [15:0] data_ina,
  output logic [15:0] data_inb,
  output logic        busy,
  output logic        err,
  output logic [1:0]  state_dbg
);

  // The counter must be able to hold NWORDS itself. "Full" is then a
  // reachable value, so the counter never wraps.
  localparam int CW = $clog2(NWORDS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NWORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          go_acc;
  logic          accept;

  assign go_acc    = (state == IDLE) && go;
  assign s_ready   = (state == LOAD) && (cnt < CNT_FULL);
  assign accept    = s_valid && s_ready;
  assign start     = (state == LOAD) || (state == SETTLE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (go) state_next = LOAD;
      // cnt reaches CNT_FULL on the edge that takes the last word. The FSM
      // therefore leaves LOAD only after the final write cycle.
      LOAD:   if (cnt == CNT_FULL) state_next = SETTLE;
      SETTLE: state_next = RUN;
      RUN:    if (done_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Word counter, mode latch and the one-cycle write pipeline
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      mode        <= 1'b0;
      we          <= 1'b0;
      address_ina <= 8'd0;
      address_inb <= 8'd0;
      data_ina    <= 16'd0;
      data_inb    <= 16'd0;
    end else begin
      we <= accept;
      if (go_acc) begin
        cnt  <= '0;
        mode <= mode_sel;
      end
      if (accept) begin
        cnt         <= cnt + CW'(1);
        address_ina <= 8'({cnt, 1'b0});
        address_inb <= 8'({cnt, 1'b1});
        data_ina    <= s_data[31:16];
        data_inb    <= s_data[15:0];
      end
    end
  end

`ifdef COEFF_RANGE_CHECK_EN
  // The comparison is one bit wider than the data, so any Q up to 65536 is
  // representable.
  localparam logic [16:0] Q_LIM = 17'(Q);
  logic even_oor;
  logic odd_oor;

  assign even_oor = ({1'b0, s_data[31:16]} >= Q_LIM);
  assign odd_oor  = ({1'b0, s_data[15:0]}  >= Q_LIM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (go_acc) begin
      err <= 1'b0;
    end else if (accept && (even_oor || odd_oor)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_coeff_loader.sv
module tb_coeff_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        mode_sel;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        done_in;
  logic        start;
  logic        mode;
  logic        we;
  logic [7:0]  address_ina;
  logic [7:0]  address_inb;
  logic [15:0] data_ina;
  logic [15:0] data_inb;
  logic        busy;
  logic        err;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_SETTLE = 2'd2, S_RUN = 2'd3;

`ifdef COEFF_RANGE_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  coeff_loader #(.NWORDS(128), .Q(3329)) dut (
    .clk(clk), .rst(rst), .go(go), .mode_sel(mode_sel),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .done_in(done_in), .start(start), .mode(mode), .we(we),
    .address_ina(address_ina), .address_inb(address_inb),
    .data_ina(data_ina), .data_inb(data_inb),
    .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // Step one rising edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go(input logic m);
    go = 1'b1; mode_sel = m;
    tick();
    go = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; go = 1'b0; mode_sel = 1'b0; s_valid = 1'b0;
    s_data = 32'd0; done_in = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({start, we, s_ready, busy, mode, err} !== 6'b0 || state_dbg !== S_IDLE) begin
      n_bad++;
      $display("FAIL reset_ctrl: start=%b we=%b s_ready=%b busy=%b mode=%b err=%b state=%0d, required all 0",
               start, we, s_ready, busy, mode, err, state_dbg);
    end
    n_cmp++;
    if ({address_ina, address_inb, data_ina, data_inb} !== 48'd0) begin
      n_bad++;
      $display("FAIL reset_data: a=%h b=%h da=%h db=%h, required 0", address_ina, address_inb, data_ina, data_inb);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_full_load();
    pulse_go(1'b0);
    n_cmp++;
    if (start !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b1 || we !== 1'b0 || state_dbg !== S_LOAD) begin
      n_bad++;
      $display("FAIL load_entry: start=%b s_ready=%b busy=%b we=%b state=%0d, required 1 1 1 0 1",
               start, s_ready, busy, we, state_dbg);
    end
    for (int k = 0; k < 128; k++) begin
      s_valid = 1'b1;
      s_data  = 32'h0001_0002 * k;
      tick();
      n_cmp++;
      if (we !== 1'b1 || address_ina !== 8'(2*k) || address_inb !== 8'(2*k+1) ||
          data_ina !== 16'(k) || data_inb !== 16'(2*k)) begin
        n_bad++;
        $display("FAIL full_write k=%0d: we=%b a=%0d b=%0d da=%h db=%h, required 1 %0d %0d %h %h",
                 k, we, address_ina, address_inb, data_ina, data_inb, 2*k, 2*k+1, 16'(k), 16'(2*k));
      end
    end
    s_valid = 1'b0;
    n_cmp++;
    if (start !== 1'b1 || s_ready !== 1'b0 || address_inb !== 8'd255) begin
      n_bad++;
      $display("FAIL last_write: start=%b s_ready=%b b=%0d, required 1 0 255", start, s_ready, address_inb);
    end
    tick();
    n_cmp++;
    if (state_dbg !== S_SETTLE || start !== 1'b1 || we !== 1'b0) begin
      n_bad++;
      $display("FAIL settle: state=%0d start=%b we=%b, required 2 1 0", state_dbg, start, we);
    end
    n_cmp++;
    if (address_ina !== 8'd254 || data_ina !== 16'd127) begin
      n_bad++;
      $display("FAIL hold: a=%0d da=%h, required 254 007f", address_ina, data_ina);
    end
    tick();
    n_cmp++;
    if (state_dbg !== S_RUN || start !== 1'b0 || busy !== 1'b1 || mode !== 1'b0) begin
      n_bad++;
      $display("FAIL run_entry: state=%0d start=%b busy=%b mode=%b, required 3 0 1 0", state_dbg, start, busy, mode);
    end
  endtask

  task automatic test_done();
    // go in RUN must be ignored
    pulse_go(1'b1);
    n_cmp++;
    if (state_dbg !== S_RUN || mode !== 1'b0) begin
      n_bad++;
      $display("FAIL go_in_run: state=%0d mode=%b, required 3 0", state_dbg, mode);
    end
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    n_cmp++;
    if (state_dbg !== S_IDLE || busy !== 1'b0 || start !== 1'b0) begin
      n_bad++;
      $display("FAIL done: state=%0d busy=%b start=%b, required 0 0 0", state_dbg, busy, start);
    end
    // done in IDLE is ignored, and the FSM stays in IDLE without go
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    n_cmp++;
    if (state_dbg !== S_IDLE) begin
      n_bad++;
      $display("FAIL done_idle: state=%0d, required 0", state_dbg);
    end
  endtask

  task automatic test_stall();
    int sent = 0;
    int nwr  = 0;
    int exp_k = 0;
    logic acc;
    pulse_go(1'b0);
    for (int i = 0; i < 400 && exp_k < 128; i++) begin
      s_valid = (i % 2 == 0) && (sent < 128);
      s_data  = {16'(sent), 16'(300 - sent)};
      // A go pulse mid-load must not clear the counter.
      go = (sent == 60) && s_valid;
      acc = s_valid;
      if (acc) sent++;
      tick();
      go = 1'b0;
      if (we === 1'b1) nwr++;
      n_cmp++;
      if (acc) begin
        if (we !== 1'b1 || address_ina !== 8'(2*exp_k) || address_inb !== 8'(2*exp_k+1) ||
            data_ina !== 16'(exp_k) || data_inb !== 16'(300 - exp_k)) begin
          n_bad++;
          $display("FAIL stall_write k=%0d: we=%b a=%0d b=%0d da=%h db=%h, required 1 %0d %0d",
                   exp_k, we, address_ina, address_inb, data_ina, data_inb, 2*exp_k, 2*exp_k+1);
        end
        exp_k++;
      end else if (we !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_gap i=%0d: we=%b, required 0", i, we);
      end
    end
    s_valid = 1'b0;
    n_cmp++;
    if (nwr !== 128) begin
      n_bad++;
      $display("FAIL stall_count: writes=%0d, required 128", nwr);
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_err: err=%b, required 0", err);
    end
    // done_in ignored in LOAD and SETTLE, honoured on the RUN entry cycle
    done_in = 1'b1;
    tick();
    n_cmp++;
    if (state_dbg !== S_SETTLE) begin
      n_bad++;
      $display("FAIL settle_done: state=%0d, required 2", state_dbg);
    end
    tick();
    n_cmp++;
    if (state_dbg !== S_RUN || start !== 1'b0) begin
      n_bad++;
      $display("FAIL run_done: state=%0d start=%b, required 3 0", state_dbg, start);
    end
    tick();
    done_in = 1'b0;
    n_cmp++;
    if (state_dbg !== S_IDLE || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL run_entry_done: state=%0d busy=%b, required 0 0", state_dbg, busy);
    end
  endtask

  task automatic test_midload_reset();
    pulse_go(1'b0);
    for (int k = 0; k < 50; k++) begin
      s_valid = 1'b1;
      s_data  = {16'(k + 1000), 16'(k + 2000)};
      tick();
    end
    n_cmp++;
    if (address_ina !== 8'd98 || address_inb !== 8'd99 || data_ina !== 16'd1049) begin
      n_bad++;
      $display("FAIL word50: a=%0d b=%0d da=%0d, required 98 99 1049", address_ina, address_inb, data_ina);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (start !== 1'b0 || we !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0 || state_dbg !== S_IDLE ||
        address_ina !== 8'd0 || data_ina !== 16'd0) begin
      n_bad++;
      $display("FAIL midreset: start=%b we=%b s_ready=%b busy=%b state=%0d a=%0d da=%h, required all 0",
               start, we, s_ready, busy, state_dbg, address_ina, data_ina);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (we !== 1'b0 || state_dbg !== S_IDLE) begin
      n_bad++;
      $display("FAIL abandoned: we=%b state=%0d, required 0 0", we, state_dbg);
    end
    s_valid = 1'b0;
    pulse_go(1'b0);
    s_valid = 1'b1;
    s_data  = 32'h0123_0456;
    tick();
    s_valid = 1'b0;
    n_cmp++;
    if (we !== 1'b1 || address_ina !== 8'd0 || address_inb !== 8'd1 || data_ina !== 16'h0123 || data_inb !== 16'h0456) begin
      n_bad++;
      $display("FAIL restart: we=%b a=%0d b=%0d da=%h db=%h, required 1 0 1 0123 0456",
               we, address_ina, address_inb, data_ina, data_inb);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_range();
    pulse_go(1'b0);
    s_valid = 1'b1;
    s_data  = 32'h0D01_0005;
    tick();
    n_cmp++;
    if (we !== 1'b1 || data_ina !== 16'h0D01 || data_inb !== 16'h0005 || err !== ERR_EXP) begin
      n_bad++;
      $display("FAIL range: we=%b da=%h db=%h err=%b, required 1 0d01 0005 %b", we, data_ina, data_inb, err, ERR_EXP);
    end
    s_data = 32'h0D00_0001;
    tick();
    s_valid = 1'b0;
    n_cmp++;
    if (err !== ERR_EXP || data_ina !== 16'h0D00) begin
      n_bad++;
      $display("FAIL range_sticky: err=%b da=%h, required %b 0d00", err, data_ina, ERR_EXP);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_intt();
    pulse_go(1'b1);
    mode_sel = 1'b0;
    n_cmp++;
    if (mode !== 1'b1) begin
      n_bad++;
      $display("FAIL intt_mode: mode=%b, required 1", mode);
    end
    for (int k = 0; k < 128; k++) begin
      s_valid  = 1'b1;
      mode_sel = k[0];
      s_data   = {16'(k), 16'(k)};
      tick();
    end
    s_valid = 1'b0;
    tick(); tick();
    n_cmp++;
    if (state_dbg !== S_RUN || mode !== 1'b1 || start !== 1'b0) begin
      n_bad++;
      $display("FAIL intt_run: state=%0d mode=%b start=%b, required 3 1 0", state_dbg, mode, start);
    end
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    tick();
    n_cmp++;
    if (state_dbg !== S_IDLE || mode !== 1'b1) begin
      n_bad++;
      $display("FAIL intt_idle: state=%0d mode=%b, required 0 1", state_dbg, mode);
    end
    pulse_go(1'b0);
    n_cmp++;
    if (mode !== 1'b0 || state_dbg !== S_LOAD) begin
      n_bad++;
      $display("FAIL intt_next_go: mode=%b state=%0d, required 0 1", mode, state_dbg);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_done();
    test_stall();
    test_midload_reset();
    test_range();
    test_intt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
